alu_muldiv_seq: RTL and testbench
=================================

# alu_muldiv_seq

Multi-cycle sequencer that computes unsigned 32×32 multiply (64-bit product) and unsigned 32/32 divide (quotient and remainder). It uses the shared 32-bit ALU for its add and subtract steps. The block sits beside the ALU and drives its `a`, `b`, `Binvert`, `CarryIn` and `Operation` inputs through a start/busy/done handshake. It performs one shift-add or shift-subtract iteration per clock. It holds no adder of its own; all arithmetic goes through the external ALU port pair.

## Interface
- Parameters: none. Width is fixed at 32.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  1  operation select: 0 = multiply, 1 = divide.
- `opa`  in  32  multiplicand (mul) or dividend (div).
- `opb`  in  32  multiplier (mul) or divisor (div).
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; result valid.
- `result_hi`  out  32  product[63:32] (mul) or remainder (div).
- `result_lo`  out  32  product[31:0] (mul) or quotient (div).
- `div_by_zero`  out  1  high with `done` when a divide had `opb`=0; held until the next accepted start.
- `alu_a`  out  32  to ALU `a`.
- `alu_b`  out  32  to ALU `b`.
- `alu_binvert`  out  1  to ALU `Binvert`.
- `alu_cin`  out  1  to ALU `CarryIn`.
- `alu_operation`  out  2  to ALU `Operation`.
- `alu_result`  in  32  from ALU `Result`; combinational, same cycle.
- `alu_cout`  in  1  from ALU `CarryOut`.

## Operation
- **States:** IDLE → RUN → DONE → IDLE. The divide-by-zero path goes IDLE → DONE.
- **IDLE:** on `start`=1, latch `op`, `opa` and `opb`, clear the iteration count, clear `div_by_zero`, and go to RUN.
  - Mul initialisation: hi=0, lo=`opb`, operand=`opa`.
  - Div initialisation: hi=0, lo=`opa`, operand=`opb`.
  - Div with `opb`=0: load hi=`opa`, lo=32'hFFFFFFFF, set `div_by_zero`, and go straight to DONE.
- **RUN, multiply** (ALU: operation=2'b10, binvert=0, cin=0, a=hi, b=operand):
  - lo[0]=1: {hi,lo} ← {alu_cout, alu_result, lo[31:1]}.
  - lo[0]=0: {hi,lo} ← {1'b0, hi, lo[31:1]}.
- **RUN, divide, restoring** (ALU: operation=2'b10, binvert=1, cin=1, a={hi[30:0],lo[31]}, b=operand):
  - The subtract succeeds when hi[31]=1 or alu_cout=1 (this covers the 33-bit shifted remainder).
  - Success: hi ← alu_result, lo ← {lo[30:0],1}.
  - Failure: hi ← {hi[30:0],lo[31]}, lo ← {lo[30:0],0}.
- **Iteration count:** exactly 32 RUN iterations, count 0..31. The 32nd update moves the FSM to DONE.
- **DONE:** `done`=1 for one cycle, then IDLE. `result_hi`, `result_lo` and `div_by_zero` hold until the next accepted start.
- **ALU drive outside RUN:** all ALU drive outputs are 0 (operation=2'b00).
- **Start handling:** `start` is ignored in RUN and DONE. A start held high is re-accepted in the first IDLE cycle after DONE.
- **Outputs:** all outputs except the ALU drive are registered. The ALU drive is decoded combinationally from state and registers.

## Timing
- **Reset:** asynchronous, active-low. All registers go to 0, state to IDLE, and `busy`=`done`=`div_by_zero`=0. `result_hi`=`result_lo`=0 and the ALU drive is 0.
- **Reset mid-RUN or mid-DONE:** aborts immediately; no `done` is issued. The first rising edge after release may accept `start`.
- **Normal latency:** start accepted at edge E0 → RUN updates at E1..E32 → `done` high during the cycle following E32 → IDLE at E33.
  - Back-to-back throughput is one operation per 34 cycles.
- **Divide-by-zero latency:** start at E0 → `done` high during the cycle following E0 → IDLE at E1.
- **Combinational path:** one ALU pass per clock (alu_* out → alu_result/alu_cout in → register D) must close in one clock.
- **Results:** valid from the `done` cycle onward. During RUN they show intermediate working values.

## Test plan
- Multiply 32'hFFFFFFFF × 32'hFFFFFFFF → `result_hi`=32'hFFFFFFFE, `result_lo`=32'h00000001. `done` appears exactly 32 cycles after the start edge and `busy` is high for 33 cycles.
- Multiply 32'hA5A5A5A5 × 2 → hi=32'h00000001, lo=32'h4B4B4B4A. During RUN, check `alu_operation`=2'b10, `alu_binvert`=0 and `alu_cin`=0.
- Divide 100 / 7 → lo=32'h0000000E, hi=32'h00000002. Divide 32'hFFFFFFFF / 32'h80000001 → lo=1, hi=32'h7FFFFFFE; this exercises the hi[31] path. During RUN, check `alu_binvert`=1 and `alu_cin`=1.
- Divide 32'h12345678 / 0 → `done` one cycle after the start edge, lo=32'hFFFFFFFF, hi=32'h12345678, `div_by_zero`=1. A following multiply clears `div_by_zero`.
- Hold `start`=1 continuously with changing `opa` and `opb` → operands change only at acceptance. Results match the values latched at each IDLE acceptance, with a 34-cycle cadence.
- Assert `reset_n`=0 at RUN iteration 10 → `busy`, `done`, results and ALU drive are 0 immediately. After release, 7 × 6 gives hi=0, lo=42 with normal latency.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// Sequential unsigned 32x32 multiply / 32/32 restoring divide, one iteration per clock.
// All add/subtract steps are routed through the shared external ALU.
//
// state  | meaning
// IDLE   | waiting for start; ALU drive held at zero
// RUN    | 32 shift-add (mul) or shift-subtract (div) iterations
// DONE   | one-cycle done pulse; results held afterwards
module alu_muldiv_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_hi,
  output logic [31:0] result_lo,
  output logic        div_by_zero,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_binvert,
  output logic        alu_cin,
  output logic [1:0]  alu_operation,
  input  logic [31:0] alu_result,
  input  logic        alu_cout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        op_q, op_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] operand_q, operand_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        dbz_q, dbz_d;
  logic        sub_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      op_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      operand_q <= '0;
      cnt_q     <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      operand_q <= operand_d;
      cnt_q     <= cnt_d;
      dbz_q     <= dbz_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    operand_d     = operand_q;
    cnt_d         = cnt_q;
    dbz_d         = dbz_q;
    alu_a         = '0;
    alu_b         = '0;
    alu_binvert   = 1'b0;
    alu_cin       = 1'b0;
    alu_operation = 2'b00;
    sub_ok        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op;
          cnt_d = '0;
          dbz_d = 1'b0;
          hi_d  = '0;
          if (!op) begin
            lo_d      = opb;
            operand_d = opa;
            state_d   = S_RUN;
          end else if (opb == 32'd0) begin
            // Divide by zero skips RUN entirely and reports a saturated quotient.
            hi_d      = opa;
            lo_d      = 32'hFFFF_FFFF;
            operand_d = opb;
            dbz_d     = 1'b1;
            state_d   = S_DONE;
          end else begin
            lo_d      = opa;
            operand_d = opb;
            state_d   = S_RUN;
          end
        end
      end

      S_RUN: begin
        alu_operation = 2'b10;
        alu_b         = operand_q;
        if (!op_q) begin
          alu_a = hi_q;
          if (lo_q[0]) {hi_d, lo_d} = {alu_cout, alu_result, lo_q[31:1]};
          else         {hi_d, lo_d} = {1'b0, hi_q, lo_q[31:1]};
        end else begin
          alu_a       = {hi_q[30:0], lo_q[31]};
          alu_binvert = 1'b1;
          alu_cin     = 1'b1;
          // hi[31] set means the shifted remainder is 33 bits wide and always exceeds the divisor.
          sub_ok      = hi_q[31] | alu_cout;
          if (sub_ok) begin
            hi_d = alu_result;
            lo_d = {lo_q[30:0], 1'b1};
          end else begin
            hi_d = {hi_q[30:0], lo_q[31]};
            lo_d = {lo_q[30:0], 1'b0};
          end
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_DONE;
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign result_hi   = hi_q;
  assign result_lo   = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq with a behavioural model of the shared ALU.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        op;
  logic [31:0] opa, opb;
  logic        busy, done, div_by_zero;
  logic [31:0] result_hi, result_lo;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_binvert, alu_cin, alu_cout;
  logic [1:0]  alu_operation;

  alu_muldiv_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .result_hi(result_hi), .result_lo(result_lo),
    .div_by_zero(div_by_zero), .alu_a(alu_a), .alu_b(alu_b),
    .alu_binvert(alu_binvert), .alu_cin(alu_cin), .alu_operation(alu_operation),
    .alu_result(alu_result), .alu_cout(alu_cout)
  );

  always #5 clk = ~clk;

  // Shared ALU: and / or / add with optional B inversion and carry-in.
  logic [31:0] b_eff;
  logic [32:0] sum;
  always_comb begin
    b_eff = alu_binvert ? ~alu_b : alu_b;
    sum   = {1'b0, alu_a} + {1'b0, b_eff} + {32'd0, alu_cin};
    alu_cout = sum[32];
    case (alu_operation)
      2'b00:   alu_result = alu_a & b_eff;
      2'b01:   alu_result = alu_a | b_eff;
      2'b10:   alu_result = sum[31:0];
      default: alu_result = 32'd0;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          done_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result_hi", 64'(result_hi), 64'(e.hi));
        chk("result_lo", 64'(result_lo), 64'(e.lo));
        chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
        chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
      end
    end
  end

  task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input logic ed);
    int c0;
    int bc;
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    @(posedge clk);
    #1;
    c0 = cyc;
    e.hi = eh; e.lo = el; e.dbz = ed; e.done_cyc = c0 + (ed ? 0 : 32);
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("alu_drive_first", {29'd0, alu_operation, alu_binvert, alu_cin},
        ed ? 64'd0 : {29'd0, 2'b10, o, o});
    bc = 0;
    while (busy && bc < 100) begin
      bc++;
      @(negedge clk);
    end
    chk("busy_cycles", 64'(bc), ed ? 64'd1 : 64'd33);
    chk("hold_results", {result_hi, result_lo}, {eh, el});
    chk("hold_dbz", 64'(div_by_zero), 64'(ed));
    chk("idle_alu_drive", {alu_a, alu_b} | 64'({alu_operation, alu_binvert, alu_cin}), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_lo [3];
    int w;
    exp_t e;
    held_lo[0] = 32'd2;
    held_lo[1] = 32'd3708;
    held_lo[2] = 32'd14350;

    reset_n = 1'b0; start = 1'b0; op = 1'b0; opa = '0; opb = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, div_by_zero, result_hi, result_lo}, 64'd0);
    chk("reset_alu_drive", {alu_a, alu_b} | 64'({alu_operation, alu_binvert, alu_cin}), 64'd0);
    reset_n = 1'b1;

    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    do_op(1'b0, 32'hA5A5_A5A5, 32'd2,         32'h0000_0001, 32'h4B4B_4B4A, 1'b0);
    do_op(1'b1, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0);
    do_op(1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'h0000_0001, 1'b0);
    do_op(1'b1, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
    do_op(1'b0, 32'd3,         32'd5,         32'h0000_0000, 32'h0000_000F, 1'b0);

    // start held high with operands changing every cycle: acceptances at k = 0, 34, 68
    for (int k = 0; k < 102; k++) begin
      @(negedge clk);
      start = 1'b1; op = 1'b0; opa = 32'(k * 3 + 1); opb = 32'(k + 2);
      if (k % 34 == 0) begin
        e.hi = 32'd0; e.lo = held_lo[k / 34]; e.dbz = 1'b0; e.done_cyc = cyc + 1 + 32;
        sb_q.push_back(e);
      end
    end
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (sb_q.size() != 0 && w < 200) begin
      w++;
      @(negedge clk);
    end
    chk("held_start_drain", 64'(sb_q.size()), 64'd0);

    // reset during RUN iteration 10
    @(negedge clk);
    start = 1'b1; op = 1'b0; opa = 32'hFFFF_FFFF; opb = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("busy_before_reset", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("midrun_reset_outputs", {busy, done, div_by_zero, result_hi, result_lo}, 64'd0);
    chk("midrun_reset_alu", {alu_a, alu_b} | 64'({alu_operation, alu_binvert, alu_cin}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    do_op(1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0);

    repeat (3) @(negedge clk);
    chk("final_drain", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
